// File: rtl/bbox_sample_walker.sv
// Raster walker over a triangle's bounding box: emits one sample point per cycle,
// with the captured triangle and colour, to the sample test stage.
module bbox_sample_walker #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]            color_R13U,
    input  logic [1:0][1:0][SIGFIG-1:0]              box_R13S,
    input  logic                                     validTri_R13H,
    output logic                                     halt_RnnnnL,
    input  logic [3:0]                               subSample_RnnnnU,
    input  logic                                     haltDn_R14H,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R14S,
    output logic [COLORS-1:0][SIGFIG-1:0]            color_R14U,
    output logic [1:0][SIGFIG-1:0]                   sample_R14S,
    output logic                                     validSamp_R14H,
    output logic                                     lastSamp_R14H
);

    typedef enum logic [0:0] {
        S_WAIT = 1'b0,
        S_TEST = 1'b1
    } state_t;

    // One-hot subsample mode to grid spacing; an illegal mode falls back to one pixel.
    function automatic logic [SIGFIG-1:0] step_of(input logic [3:0] mode);
        logic [SIGFIG-1:0] one;
        logic [SIGFIG-1:0] s;
        one = {{(SIGFIG-1){1'b0}}, 1'b1};
        case (mode)
            4'b0001: s = one << (RADIX - 3);
            4'b0010: s = one << (RADIX - 2);
            4'b0100: s = one << (RADIX - 1);
            4'b1000: s = one << RADIX;
            default: s = one << RADIX;
        endcase
        return s;
    endfunction

    state_t                                  r_state;
    logic                                    r_halt;
    logic                                    r_valid;
    logic                                    r_last;
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  r_tri;
    logic [COLORS-1:0][SIGFIG-1:0]           r_color;
    logic [1:0][SIGFIG-1:0]                  r_sample;
    logic [SIGFIG-1:0]                       r_step;
    logic [SIGFIG-1:0]                       r_ll_x;
    logic [SIGFIG-1:0]                       r_ur_x;
    logic [SIGFIG-1:0]                       r_ur_y;

    logic [SIGFIG-1:0] w_step;
    logic [SIGFIG-1:0] w_mask;
    logic [SIGFIG-1:0] w_ll_x;
    logic [SIGFIG-1:0] w_ll_y;
    logic [SIGFIG-1:0] w_ur_x;
    logic [SIGFIG-1:0] w_ur_y;
    logic              w_empty;
    logic              w_single;
    logic              w_row_end;
    logic [SIGFIG-1:0] w_next_x;
    logic [SIGFIG-1:0] w_next_y;
    logic              w_next_last;

    // Capture-side decode: grid step and box snapped down onto the sample grid.
    always_comb begin
        w_step   = step_of(subSample_RnnnnU);
        w_mask   = ~(w_step - {{(SIGFIG-1){1'b0}}, 1'b1});
        w_ll_x   = box_R13S[0][0] & w_mask;
        w_ll_y   = box_R13S[0][1] & w_mask;
        w_ur_x   = box_R13S[1][0] & w_mask;
        w_ur_y   = box_R13S[1][1] & w_mask;
        w_empty  = ($signed(w_ll_x) > $signed(w_ur_x)) || ($signed(w_ll_y) > $signed(w_ur_y));
        w_single = (w_ll_x == w_ur_x) && (w_ll_y == w_ur_y);
    end

    // Next raster position from the currently presented sample.
    always_comb begin
        w_row_end = (r_sample[0] == r_ur_x);
        if (w_row_end) begin
            w_next_x = r_ll_x;
            w_next_y = r_sample[1] + r_step;
        end else begin
            w_next_x = r_sample[0] + r_step;
            w_next_y = r_sample[1];
        end
        w_next_last = (w_next_x == r_ur_x) && (w_next_y == r_ur_y);
    end

    // Walker FSM; the presented sample register doubles as the cursor.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_WAIT;
            r_halt   <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_tri    <= '0;
            r_color  <= '0;
            r_sample <= '0;
            r_step   <= '0;
            r_ll_x   <= '0;
            r_ur_x   <= '0;
            r_ur_y   <= '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    r_halt  <= 1'b0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    if (validTri_R13H) begin
                        r_tri       <= tri_R13S;
                        r_color     <= color_R13U;
                        r_step      <= w_step;
                        r_ll_x      <= w_ll_x;
                        r_ur_x      <= w_ur_x;
                        r_ur_y      <= w_ur_y;
                        r_sample[0] <= w_ll_x;
                        r_sample[1] <= w_ll_y;
                        if (!w_empty) begin
                            r_state <= S_TEST;
                            r_halt  <= 1'b1;
                            r_valid <= 1'b1;
                            r_last  <= w_single;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_TEST: begin
                    if (haltDn_R14H) begin
                        r_state <= S_TEST;
                    end else if (r_last) begin
                        r_state <= S_WAIT;
                        r_halt  <= 1'b0;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end else begin
                        r_sample[0] <= w_next_x;
                        r_sample[1] <= w_next_y;
                        r_last      <= w_next_last;
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                    r_halt  <= 1'b0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end
            endcase
        end
    end

    assign halt_RnnnnL    = r_halt;
    assign tri_R14S       = r_tri;
    assign color_R14U     = r_color;
    assign sample_R14S    = r_sample;
    assign validSamp_R14H = r_valid;
    assign lastSamp_R14H  = r_last;

endmodule
